// File: rtl/seven_seg_bcd_display.sv
// Sequential binary-to-BCD seven-segment driver: double-dabble one bit per cycle,
// then one encode cycle that registers active-low segment patterns.
module seven_seg_bcd_display #(
  parameter int unsigned IN_WIDTH      = 8,
  parameter int unsigned NUM_DIGITS    = 3,
  parameter bit          BLANK_LEADING = 1'b1,
  parameter bit          ZERO_DARK     = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [IN_WIDTH-1:0]       i_value,
  output logic [NUM_DIGITS*7-1:0]   o_seven,
  output logic                      o_done,
  output logic                      o_ovf
);

  localparam int unsigned BCD_W = NUM_DIGITS * 4;
  localparam int unsigned SEG_W = NUM_DIGITS * 7;
  localparam int unsigned CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_WIDTH - 1);
  localparam logic [6:0] SEG_DARK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_ENCODE
  } state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
  logic                ovf_flag_q, ovf_flag_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEG_W-1:0]    seven_d, enc_seven;
  logic                done_d, ovf_d;
  logic [3:0]          adj_nib, enc_nib;
  logic                nz_seen;

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles go dark.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1011000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_DARK;
    endcase
  endfunction

  // Add-3 correction on every nibble that is 5 or more.
  always_comb begin
    bcd_adj = '0;
    adj_nib = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      adj_nib = bcd_q[4*k +: 4];
      bcd_adj[4*k +: 4] = (adj_nib >= 4'd5) ? adj_nib + 4'd3 : adj_nib;
    end
  end

  // Digit patterns from the finished BCD value, walking from the top digit down.
  always_comb begin
    enc_seven = '0;
    enc_nib   = '0;
    nz_seen   = 1'b0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      enc_nib = bcd_q[4*k +: 4];
      if (enc_nib != 4'd0) nz_seen = 1'b1;
      if (ovf_flag_q)
        enc_seven[7*k +: 7] = SEG_DASH;
      else if (ZERO_DARK && (bcd_q == '0))
        enc_seven[7*k +: 7] = SEG_DARK;
      else if (BLANK_LEADING && !nz_seen && (k != 0))
        enc_seven[7*k +: 7] = SEG_DARK;
      else
        enc_seven[7*k +: 7] = seg_of(enc_nib);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    ovf_flag_d = ovf_flag_q;
    cnt_d      = cnt_q;
    seven_d    = o_seven;
    ovf_d      = o_ovf;
    done_d     = 1'b0;
    o_ready    = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          shift_d    = i_value;
          bcd_d      = '0;
          ovf_flag_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_CONVERT;
        end
      end
      S_CONVERT: begin
        {bcd_d, shift_d} = {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
        ovf_flag_d       = ovf_flag_q | bcd_adj[BCD_W-1];
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) state_d = S_ENCODE;
      end
      S_ENCODE: begin
        seven_d = enc_seven;
        ovf_d   = ovf_flag_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      ovf_flag_q <= 1'b0;
      cnt_q      <= '0;
      o_seven    <= {SEG_W{1'b1}};
      o_done     <= 1'b0;
      o_ovf      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      ovf_flag_q <= ovf_flag_d;
      cnt_q      <= cnt_d;
      o_seven    <= seven_d;
      o_done     <= done_d;
      o_ovf      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_bcd_display.sv
// Bench for seven_seg_bcd_display: three instances (defaults, ZERO_DARK=0, IN_WIDTH=10)
// checked against a decimal-arithmetic reference model.
module tb_seven_seg_bcd_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid [3];
  logic [9:0]  val   [3];
  logic        ready [3];
  logic        done  [3];
  logic        ovf   [3];
  logic [20:0] seven [3];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  localparam logic [20:0] ALL_DARK = 21'h1FFFFF;

  always #5 clk = ~clk;

  seven_seg_bcd_display #(.IN_WIDTH(8), .NUM_DIGITS(3), .BLANK_LEADING(1'b1), .ZERO_DARK(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .o_ready(ready[0]), .i_value(val[0][7:0]),
    .o_seven(seven[0]), .o_done(done[0]), .o_ovf(ovf[0]));

  seven_seg_bcd_display #(.IN_WIDTH(8), .NUM_DIGITS(3), .BLANK_LEADING(1'b1), .ZERO_DARK(1'b0)) dut_z (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .o_ready(ready[1]), .i_value(val[1][7:0]),
    .o_seven(seven[1]), .o_done(done[1]), .o_ovf(ovf[1]));

  seven_seg_bcd_display #(.IN_WIDTH(10), .NUM_DIGITS(3), .BLANK_LEADING(1'b1), .ZERO_DARK(1'b1)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[2]), .o_ready(ready[2]), .i_value(val[2]),
    .o_seven(seven[2]), .o_done(done[2]), .o_ovf(ovf[2]));

  function automatic int unsigned width_of(input int d);
    return (d == 2) ? 10 : 8;
  endfunction

  function automatic bit zd_of(input int d);
    return (d == 1) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [6:0] digit_seg(input int unsigned n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1011000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Expected display for a 3-digit driver with leading blanking enabled.
  function automatic logic [20:0] exp_seven(input int unsigned v, input bit zd);
    logic [20:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    if (v > 999) return {3{7'b0111111}};
    for (int k = 0; k < 3; k++) begin
      if ((k > 0 && v < p) || (zd && v == 0))
        r[7*k +: 7] = 7'b1111111;
      else
        r[7*k +: 7] = digit_seg((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait from the first negedge after an accept edge until o_done; returns cycles elapsed.
  task automatic wait_done(input int d, output int cnt);
    cnt = 0;
    while (done[d] !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic conv(input int d, input int unsigned v);
    int cnt;
    logic [20:0] e;
    e = exp_seven(v, zd_of(d));
    @(negedge clk);
    check("ready_before", 32'(ready[d]), 32'd1);
    valid[d] = 1'b1;
    val[d]   = 10'(v);
    @(negedge clk);
    valid[d] = 1'b0;
    wait_done(d, cnt);
    check("latency", 32'(cnt), 32'(width_of(d) + 1));
    check("seven", 32'(seven[d]), 32'(e));
    check("ovf", 32'(ovf[d]), 32'(v > 999));
    check("ready_at_done", 32'(ready[d]), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(done[d]), 32'd0);
    check("seven_hold", 32'(seven[d]), 32'(e));
  endtask

  initial begin
    int  cnt;
    bit  seen_done;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      valid[d] = 1'b0;
      val[d]   = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_seven", 32'(seven[d]), 32'(ALL_DARK));
      check("rst_ovf", 32'(ovf[d]), 32'd0);
      check("rst_done", 32'(done[d]), 32'd0);
      check("rst_ready", 32'(ready[d]), 32'd1);
    end

    // Directed values, including the digit-boundary and overflow edges.
    conv(0, 255);
    conv(0, 7);
    conv(0, 0);
    conv(1, 0);
    conv(1, 7);
    conv(0, 100);
    conv(0, 10);
    conv(2, 1000);
    conv(2, 999);
    conv(2, 1023);
    conv(2, 0);

    // Random values against the reference model.
    for (int i = 0; i < 15; i++) begin
      conv(0, $urandom_range(255));
      conv(1, $urandom_range(255));
      conv(2, $urandom_range(1023));
    end

    // i_valid held across the conversion with a value change; re-accept right after o_done.
    @(negedge clk);
    valid[0] = 1'b1;
    val[0]   = 10'd42;
    @(negedge clk);
    val[0] = 10'd13;
    wait_done(0, cnt);
    check("hold_latency", 32'(cnt), 32'd9);
    check("hold_seven", 32'(seven[0]), 32'(exp_seven(42, 1'b1)));
    check("hold_ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    check("reaccept_busy", 32'(ready[0]), 32'd0);
    valid[0] = 1'b0;
    wait_done(0, cnt);
    check("reaccept_latency", 32'(cnt), 32'd9);
    check("reaccept_seven", 32'(seven[0]), 32'(exp_seven(13, 1'b1)));

    // Reset in the middle of a conversion.
    @(negedge clk);
    valid[0] = 1'b1;
    val[0]   = 10'd200;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen_done = done[0];
    check("abort_seven", 32'(seven[0]), 32'(ALL_DARK));
    @(negedge clk);
    check("abort_ready", 32'(ready[0]), 32'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    check("abort_seven_after", 32'(seven[0]), 32'(ALL_DARK));
    for (int d = 0; d < 3; d++) check("abort_ovf", 32'(ovf[d]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
